// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state type, digit width and sizing helper for the binary-to-BCD converter
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bcd_state_t;

   // ceil(width * log10(2)), with log10(2) taken as 0.30103
   function automatic int bcd_digits_needed(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 to a BCD digit of 5 or more
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int SIGNED_MODE = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_bin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
   output logic                          out_neg,
   output logic                          out_ovf
);

   localparam int BW = BCD_DIGIT_W * DIGITS;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   if (WIDTH < 2 || DIGITS < 1 || (SIGNED_MODE != 0 && SIGNED_MODE != 1)) begin : g_bad_params
      $error("bin_to_bcd_seq: WIDTH must be >= 2, DIGITS >= 1, SIGNED_MODE 0 or 1");
   end

   bcd_state_t      state;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] mag;
   logic [BW-1:0]    bcd_q;
   logic [BW-1:0]    bcd_adj;
   logic [BW-1:0]    bcd_nxt;
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic             ovf_nxt;
   logic             neg_q;
   logic             neg_in;
   logic             accept;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .adjusted (bcd_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
   assign neg_in = (SIGNED_MODE != 0) && in_bin[WIDTH-1];
   assign mag    = neg_in ? (~in_bin) + WIDTH'(1) : in_bin;

   // Dropping the bit shifted out of the top digit leaves exactly magnitude mod 10^DIGITS
   assign bcd_nxt = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
   assign bin_nxt = {bin_q[WIDTH-2:0], 1'b0};
   assign ovf_nxt = ovf_q | bcd_adj[BW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt       <= '0;
         ovf_q     <= 1'b0;
         neg_q     <= 1'b0;
         out_valid <= 1'b0;
         out_bcd   <= '0;
         out_neg   <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               bcd_q <= bcd_nxt;
               bin_q <= bin_nxt;
               ovf_q <= ovf_nxt;
               cnt   <= cnt - CW'(1);
               if (cnt == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_bcd   <= bcd_nxt;
                  out_neg   <= neg_q;
                  out_ovf   <= ovf_nxt;
               end
            end
            IDLE, DONE: begin
               if (state == DONE && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               if (accept) begin
                  bin_q <= mag;
                  bcd_q <= '0;
                  ovf_q <= 1'b0;
                  neg_q <= neg_in;
                  cnt   <= CNT_LOAD;
                  state <= SHIFT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq in four configurations
module tb_bin_to_bcd_seq;
   import bcd_pkg::*;

   localparam int W_P [4] = '{8, 8, 8, 16};
   localparam int D_P [4] = '{3, 3, 2, 5};
   localparam bit S_P [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] iv, ordy;
   logic [3:0] ir, ov, on, oo;
   logic [7:0]  ib0, ib1, ib2;
   logic [15:0] ib3;
   logic [11:0] ob0, ob1;
   logic [7:0]  ob2;
   logic [19:0] ob3;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   logic [21:0] exp_r [4];
   logic [3:0]  have, latp;
   int          acc [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_bin(ib0),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_bcd(ob0), .out_neg(on[0]), .out_ovf(oo[0]));
   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_bin(ib1),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_bcd(ob1), .out_neg(on[1]), .out_ovf(oo[1]));
   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED_MODE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_bin(ib2),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_bcd(ob2), .out_neg(on[2]), .out_ovf(oo[2]));
   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_MODE(0)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_bin(ib3),
      .out_valid(ov[3]), .out_ready(ordy[3]), .out_bcd(ob3), .out_neg(on[3]), .out_ovf(oo[3]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: magnitude from arithmetic, then decimal digits by repeated division
   function automatic logic [21:0] model(input int w, input int d, input bit sgn,
                                         input longint unsigned v);
      longint unsigned x, mag, lim, r;
      bit neg;
      logic [19:0] bcd;
      x   = v & ((64'd1 << w) - 1);
      neg = sgn && (x >= (64'd1 << (w - 1)));
      mag = neg ? (64'd1 << w) - x : x;
      lim = 1;
      for (int k = 0; k < d; k++) lim = lim * 10;
      r   = mag % lim;
      bcd = '0;
      for (int k = 0; k < d; k++) begin
         bcd[4*k +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return {mag >= lim, neg, bcd};
   endfunction

   function automatic logic [19:0] get_bcd(input int i);
      case (i)
         0:       return {8'b0, ob0};
         1:       return {8'b0, ob1};
         2:       return {12'b0, ob2};
         default: return ob3;
      endcase
   endfunction

   function automatic logic [15:0] get_bin(input int i);
      case (i)
         0:       return {8'b0, ib0};
         1:       return {8'b0, ib1};
         2:       return {8'b0, ib2};
         default: return ib3;
      endcase
   endfunction

   task automatic set_bin(input int i, input logic [31:0] v);
      case (i)
         0:       ib0 = v[7:0];
         1:       ib1 = v[7:0];
         2:       ib2 = v[7:0];
         default: ib3 = v[15:0];
      endcase
   endtask

   // Compare process: every cycle a result is presented it must match the model
   always @(negedge clk) begin
      if (!rst_n) begin
         have = '0;
         latp = '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (ov[i]) begin
               if (latp[i]) begin
                  check($sformatf("dut%0d_latency", i), 64'(cyc - acc[i]), 64'(W_P[i]));
                  latp[i] = 1'b0;
               end
               check($sformatf("dut%0d_exp_present", i), 64'(have[i]), 64'd1);
               check($sformatf("dut%0d_bcd", i), 64'(get_bcd(i)), 64'(exp_r[i][19:0]));
               check($sformatf("dut%0d_neg", i), 64'(on[i]), 64'(exp_r[i][20]));
               check($sformatf("dut%0d_ovf", i), 64'(oo[i]), 64'(exp_r[i][21]));
               if (ordy[i]) have[i] = 1'b0;
            end
            if (iv[i] && ir[i]) begin
               exp_r[i] = model(W_P[i], D_P[i], S_P[i], 64'(get_bin(i)));
               have[i]  = 1'b1;
               latp[i]  = 1'b1;
               acc[i]   = cyc + 1;
            end
         end
      end
   end

   task automatic wait_valid(input int i);
      bit ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         ok = ov[i];
      end
      if (!ok) check($sformatf("dut%0d_result_timeout", i), 64'd0, 64'd1);
   endtask

   task automatic convert(input int i, input logic [31:0] v);
      bit ok = 1'b0;
      @(posedge clk); #1;
      set_bin(i, v);
      iv[i] = 1'b1;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         ok = ir[i];
      end
      if (!ok) check($sformatf("dut%0d_accept_timeout", i), 64'd0, 64'd1);
      @(posedge clk); #1;
      // Garbage on the inputs while shifting must not disturb the conversion
      for (int c = 0; c < 3; c++) begin
         iv[i] = 1'($urandom % 2);
         set_bin(i, $urandom);
         @(posedge clk); #1;
      end
      iv[i] = 1'b0;
      wait_valid(i);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      iv    = '0;
      ordy  = '1;
      ib0 = '0; ib1 = '0; ib2 = '0; ib3 = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_in_ready%0d", i), 64'(ir[i]), 64'd1);
         check($sformatf("rst_out_valid%0d", i), 64'(ov[i]), 64'd0);
         check($sformatf("rst_out_bcd%0d", i), 64'(get_bcd(i)), 64'd0);
      end

      check("model_ff_u", 64'(model(8, 3, 0, 255)), 64'({2'b00, 20'h00255}));
      check("model_80_s", 64'(model(8, 3, 1, 'h80)), 64'({2'b01, 20'h00128}));
      check("model_ff_s", 64'(model(8, 3, 1, 'hFF)), 64'({2'b01, 20'h00001}));
      check("model_123_d2", 64'(model(8, 2, 0, 123)), 64'({2'b10, 20'h00023}));
      check("model_ffff", 64'(model(16, 5, 0, 'hFFFF)), 64'({2'b00, 20'h65535}));
      check("digits_needed8", 64'(bcd_digits_needed(8)), 64'd3);
      check("digits_needed16", 64'(bcd_digits_needed(16)), 64'd5);

      @(posedge clk); #2;
      rst_n = 1'b1;

      convert(0, 'hFF);
      check("u_ff_bcd", 64'(ob0), 64'h255);
      check("u_ff_ovf", 64'(oo[0]), 64'd0);
      convert(0, 'h00);
      check("u_00_bcd", 64'(ob0), 64'h000);
      for (int v = 0; v < 256; v++) convert(0, 32'(v));

      convert(1, 'h80);
      check("s_80_bcd", 64'(ob1), 64'h128);
      check("s_80_neg", 64'(on[1]), 64'd1);
      convert(1, 'hFF);
      check("s_ff_bcd", 64'(ob1), 64'h001);
      check("s_ff_neg", 64'(on[1]), 64'd1);
      convert(1, 'h7F);
      check("s_7f_bcd", 64'(ob1), 64'h127);
      check("s_7f_neg", 64'(on[1]), 64'd0);
      for (int n = 0; n < 80; n++) convert(1, $urandom);

      convert(2, 200);
      check("d2_200_bcd", 64'(ob2), 64'h00);
      check("d2_200_ovf", 64'(oo[2]), 64'd1);
      convert(2, 123);
      check("d2_123_bcd", 64'(ob2), 64'h23);
      check("d2_123_ovf", 64'(oo[2]), 64'd1);
      convert(2, 99);
      check("d2_99_bcd", 64'(ob2), 64'h99);
      check("d2_99_ovf", 64'(oo[2]), 64'd0);
      for (int n = 0; n < 80; n++) convert(2, $urandom);

      convert(3, 'hFFFF);
      check("w16_ffff_bcd", 64'(ob3), 64'h65535);
      for (int n = 0; n < 40; n++) convert(3, $urandom);

      // Backpressure: result held while the consumer stalls, then overlapped accept
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      set_bin(0, 77);
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      wait_valid(0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         iv[0] = 1'($urandom % 2);
         set_bin(0, $urandom);
         @(negedge clk);
         check("bp_in_ready_low", 64'(ir[0]), 64'd0);
         check("bp_held_bcd", 64'(ob0), 64'h077);
      end
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      iv[0] = 1'b1;
      set_bin(0, 201);
      @(negedge clk);
      check("bp_in_ready_release", 64'(ir[0]), 64'd1);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      wait_valid(0);
      @(posedge clk); #1;
      check("bp_next_bcd", 64'(ob0), 64'h201);

      // Asynchronous reset in the middle of a conversion
      set_bin(0, 200);
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(ov[0]), 64'd0);
      check("mid_rst_out_bcd", 64'(ob0), 64'd0);
      check("mid_rst_out_neg", 64'(on[0]), 64'd0);
      check("mid_rst_out_ovf", 64'(oo[0]), 64'd0);
      check("mid_rst_in_ready", 64'(ir[0]), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      convert(0, 42);
      check("after_rst_42", 64'(ob0), 64'h042);

      repeat (3) @(posedge clk);
      check("all_results_drained", 64'(have), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
